systolic_sequencer: RTL and testbench

Sequences one weight-stationary pass through the 4x4 systolic array (TPU).
- Accepts a weight tile and a data tile from upstream via a start/ready handshake.
- Shifts the weights in column-vector by column-vector, holding `control` high during the load.
- Drives the data vectors in the diagonal skew pattern, waits for the array to drain, then pulses `done` so the array outputs (`pe30_out`..`pe33_out`) can be sampled.
- Sits between the host/memory interface and the TPU, and owns the TPU's `control`, `wt_arr` and `data_arr` inputs.

---
 rtl/systolic_sequencer.sv | 114 +++++++++++
 tb/tb_systolic_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// Weight-stationary pass sequencer for the DEPTH x DEPTH systolic array: latches a
// weight/data tile, shifts weights in, feeds skewed data, drains, then pulses done.
module systolic_sequencer #(
    parameter int BIT_WIDTH    = 16,
    parameter int DEPTH        = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               reuse_wt,
    input  logic [BIT_WIDTH*DEPTH*DEPTH-1:0]   wt_tile,
    input  logic [BIT_WIDTH*DEPTH*DEPTH-1:0]   data_tile,
    output logic                               ready,
    output logic                               busy,
    output logic                               control,
    output logic [BIT_WIDTH*DEPTH-1:0]         wt_arr,
    output logic [BIT_WIDTH*DEPTH-1:0]         data_arr,
    output logic                               done,
    output logic                               wt_loaded,
    output logic [2:0]                         state_dbg
);

    localparam int CNT_MAX = (2*DEPTH-1 > DRAIN_CYCLES) ? 2*DEPTH-1 : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int ROW_W   = BIT_WIDTH*DEPTH;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_FEED   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]                       state, state_nxt;
    logic [CNT_W-1:0]                 cnt;
    logic [BIT_WIDTH*DEPTH*DEPTH-1:0] wt_q, data_q;
    logic                             accept;

    // Handshake: a pass is accepted at a rising edge where start && ready;
    // start while not ready is dropped, never queued.
    assign accept    = start && ready;
    assign ready     = (state == S_IDLE) || (state == S_DONE);
    assign busy      = (state == S_LOAD_W) || (state == S_SETTLE) ||
                       (state == S_FEED) || (state == S_DRAIN);
    assign control   = (state == S_LOAD_W);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept)
                    state_nxt = (reuse_wt && wt_loaded) ? S_FEED : S_LOAD_W;
                else
                    state_nxt = S_IDLE;
            end
            S_LOAD_W: if (cnt == CNT_W'(DEPTH-1))        state_nxt = S_SETTLE;
            S_SETTLE:                                     state_nxt = S_FEED;
            S_FEED:   if (cnt == CNT_W'(2*DEPTH-2))      state_nxt = S_DRAIN;
            S_DRAIN:  if (cnt == CNT_W'(DRAIN_CYCLES-1)) state_nxt = S_DONE;
            default:                                      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wt_loaded <= 1'b0;
            wt_q      <= '0;
            data_q    <= '0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || (state_nxt == S_IDLE))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (accept) begin
                wt_q   <= wt_tile;
                data_q <= data_tile;
            end
            if (state == S_SETTLE)
                wt_loaded <= 1'b1;
        end
    end

    // Last weight row goes in first so row 0 ends up in the top PE row.
    always_comb begin
        wt_arr = '0;
        if (state == S_LOAD_W) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (cnt == CNT_W'(DEPTH-1-r))
                    wt_arr = wt_q[r*ROW_W +: ROW_W];
            end
        end
    end

    // Diagonal skew: lane l carries vector t on feed step k = t + l.
    always_comb begin
        data_arr = '0;
        if (state == S_FEED) begin
            for (int t = 0; t < DEPTH; t++) begin
                for (int l = 0; l < DEPTH; l++) begin
                    if (cnt == CNT_W'(t + l))
                        data_arr[l*BIT_WIDTH +: BIT_WIDTH] =
                            data_q[(t*DEPTH + l)*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: a per-cycle schedule model built on each accepted start,
// compared against the DUT every cycle, plus hand-computed pins for the directed passes.
module tb_systolic_sequencer;

    localparam int BW   = 16;
    localparam int D    = 4;
    localparam int ROWW = BW*D;
    localparam int TW   = BW*D*D;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            start, reuse_wt;
    logic [TW-1:0]   wt_tile, data_tile;
    logic            ready, busy, control, done, wt_loaded;
    logic [ROWW-1:0] wt_arr, data_arr;
    logic [2:0]      state_dbg;

    systolic_sequencer #(.BIT_WIDTH(BW), .DEPTH(D), .DRAIN_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .reuse_wt(reuse_wt),
        .wt_tile(wt_tile), .data_tile(data_tile),
        .ready(ready), .busy(busy), .control(control),
        .wt_arr(wt_arr), .data_arr(data_arr),
        .done(done), .wt_loaded(wt_loaded), .state_dbg(state_dbg)
    );

    // ---------------- model: expected output per cycle ----------------
    typedef struct packed {
        logic            control;
        logic [ROWW-1:0] wt;
        logic [ROWW-1:0] data;
        logic            done;
        logic            busy;
        logic            settle;
        logic            wl;
    } exp_t;

    exp_t exp_q[$];
    logic m_wl;
    int   m_cyc;
    int   m_lat;
    logic cur_ready;

    function automatic void build(input logic reuse, input logic [TW-1:0] wt, input logic [TW-1:0] dt);
        exp_t        e;
        logic [15:0] w [D][D];
        logic [15:0] dv[D][D];
        logic        wl_after;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                w[r][c]  = wt[(r*D+c)*BW +: BW];
                dv[r][c] = dt[(r*D+c)*BW +: BW];
            end
        wl_after = m_wl;
        if (!reuse || !m_wl) begin
            for (int c = 0; c < D; c++) begin
                e = '0; e.control = 1'b1; e.busy = 1'b1; e.wl = m_wl;
                for (int l = 0; l < D; l++) e.wt[l*BW +: BW] = w[D-1-c][l];
                exp_q.push_back(e);
            end
            e = '0; e.busy = 1'b1; e.settle = 1'b1; e.wl = m_wl;
            exp_q.push_back(e);
            wl_after = 1'b1;
            m_lat = 21;
        end else begin
            m_lat = 16;
        end
        for (int k = 0; k < 2*D-1; k++) begin
            e = '0; e.busy = 1'b1; e.wl = wl_after;
            for (int l = 0; l < D; l++)
                if (k - l >= 0 && k - l < D) e.data[l*BW +: BW] = dv[k-l][l];
            exp_q.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            e = '0; e.busy = 1'b1; e.wl = wl_after;
            exp_q.push_back(e);
        end
        e = '0; e.done = 1'b1; e.wl = wl_after;
        exp_q.push_back(e);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_wl  = 1'b0;
            m_cyc = 0;
        end else begin
            cur_ready = (exp_q.size() == 0) || exp_q[0].done;
            if (exp_q.size() > 0) begin
                if (exp_q[0].settle) m_wl = 1'b1;
                void'(exp_q.pop_front());
            end
            m_cyc++;
            if (start && cur_ready) begin
                build(reuse_wt, wt_tile, data_tile);
                m_cyc = 1;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    int   n_total = 0;
    int   n_bad   = 0;
    logic lit_full  = 1'b0;
    logic lit_reuse = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t cyc=%0d)", name, act, want, $time, m_cyc);
        end
    endtask

    exp_t e_cur;
    logic e_ready;
    logic pass_live;

    always begin
        @(negedge clk or negedge rst_n);
        #1;
        pass_live = (exp_q.size() > 0);
        if (pass_live) e_cur = exp_q[0];
        else begin e_cur = '0; e_cur.wl = m_wl; end
        e_ready = !pass_live || e_cur.done;
        chk("control",   64'(control),   64'(e_cur.control));
        chk("wt_arr",    64'(wt_arr),    64'(e_cur.wt));
        chk("data_arr",  64'(data_arr),  64'(e_cur.data));
        chk("done",      64'(done),      64'(e_cur.done));
        chk("busy",      64'(busy),      64'(e_cur.busy));
        chk("ready",     64'(ready),     64'(e_ready));
        chk("wt_loaded", 64'(wt_loaded), 64'(e_cur.wl));
        if (!rst_n) begin
            chk("rst_ready",    64'(ready),    64'd1);
            chk("rst_busy",     64'(busy),     64'd0);
            chk("rst_data",     64'(data_arr), 64'd0);
            chk("rst_wtloaded", 64'(wt_loaded), 64'd0);
        end
        if (rst_n && done) chk("done_latency", 64'(m_cyc), 64'(m_lat));
        if (rst_n && pass_live && lit_full) begin
            case (m_cyc)
                1:  begin chk("lit_wt1", wt_arr, 64'h0010_000f_000e_000d); chk("lit_ctl1", 64'(control), 64'd1); end
                2:  chk("lit_wt2", wt_arr, 64'h000c_000b_000a_0009);
                3:  chk("lit_wt3", wt_arr, 64'h0008_0007_0006_0005);
                4:  begin chk("lit_wt4", wt_arr, 64'h0004_0003_0002_0001); chk("lit_ctl4", 64'(control), 64'd1); end
                5:  chk("lit_ctl5", 64'(control), 64'd0);
                6:  chk("lit_k0", data_arr, 64'h0000_0000_0000_0000);
                7:  chk("lit_k1", data_arr, 64'h0000_0000_0001_0004);
                9:  chk("lit_k3", data_arr, 64'h0003_0006_0009_000c);
                12: chk("lit_k6", data_arr, 64'h000f_0000_0000_0000);
                21: chk("lit_done21", 64'(done), 64'd1);
                default: ;
            endcase
        end
        if (rst_n && pass_live && lit_reuse) begin
            case (m_cyc)
                1:  begin chk("lit_r_ctl", 64'(control), 64'd0); chk("lit_r_k0", data_arr, 64'd0); end
                2:  chk("lit_r_k1", data_arr, 64'h0000_0000_0001_0004);
                4:  chk("lit_r_k3", data_arr, 64'h0003_0006_0009_000c);
                7:  chk("lit_r_k6", data_arr, 64'h000f_0000_0000_0000);
                16: chk("lit_done16", 64'(done), 64'd1);
                default: ;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    logic [TW-1:0] w_spec, d_spec, w_alt, d_alt;

    task automatic start_pass(input logic reuse, input logic [TW-1:0] wt, input logic [TW-1:0] dt);
        @(negedge clk);
        start = 1'b1; reuse_wt = reuse; wt_tile = wt; data_tile = dt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                w_spec[(r*D+c)*BW +: BW] = 16'(r*4 + c + 1);
                d_spec[(r*D+c)*BW +: BW] = 16'(r*4 + c);
                w_alt[(r*D+c)*BW +: BW]  = 16'(16'h1100 + r*16 + c);
                d_alt[(r*D+c)*BW +: BW]  = 16'(16'h2200 + r*16 + c);
            end
        rst_n = 1'b0; start = 1'b0; reuse_wt = 1'b0; wt_tile = '0; data_tile = '0;
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(2);

        // mid-clock reset while idle: outputs checked without an edge
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // reuse requested with nothing loaded: full load anyway
        start_pass(1'b1, w_alt, d_alt);
        idle_cycles(25);

        // full pass with the reference tiles
        lit_full = 1'b1;
        start_pass(1'b0, w_spec, d_spec);
        idle_cycles(25);
        lit_full = 1'b0;

        // reuse pass
        lit_reuse = 1'b1;
        start_pass(1'b1, w_spec, d_spec);
        idle_cycles(20);

        // start pulsed during FEED with other tiles is ignored
        start_pass(1'b1, w_spec, d_spec);
        start = 1'b1; reuse_wt = 1'b0; wt_tile = w_alt; data_tile = d_alt;
        @(negedge clk);
        start = 1'b0;
        idle_cycles(20);
        lit_reuse = 1'b0;

        // back-to-back: reuse pass, then a load pass accepted in DONE
        @(negedge clk);
        start = 1'b1; reuse_wt = 1'b1; wt_tile = w_spec; data_tile = d_spec;
        idle_cycles(16);
        reuse_wt = 1'b0; wt_tile = w_alt; data_tile = d_alt;
        idle_cycles(21);
        start = 1'b0;
        idle_cycles(5);

        // abort at FEED k=3 of a reuse pass
        lit_reuse = 1'b1;
        start_pass(1'b1, w_spec, d_spec);
        idle_cycles(3);
        #3 rst_n = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        lit_reuse = 1'b0;
        idle_cycles(25);

        // reset cleared wt_loaded: reuse request loads weights again
        start_pass(1'b1, w_spec, d_spec);
        idle_cycles(25);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
